// File: rtl/uart_pkg.sv
// Shared definitions for the UART: bit-period arithmetic, FSM encodings and parity.
package uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

   function automatic int calc_cpb(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   function automatic int cnt_width(input int cpb);
      return (cpb <= 2) ? 1 : $clog2(cpb);
   endfunction

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, validates start bit at half-bit, samples mid-bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int INPUT_CLK  = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int STOP_BITS  = 2,
   parameter int PARITY_BIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_busy,
   output logic       rx_valid
);

   localparam int CPB = calc_cpb(INPUT_CLK, BAUD_RATE);
   localparam int CW  = cnt_width(CPB);
   localparam logic [CW-1:0] CPB_M1    = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_M1   = CW'(CPB / 2 - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          perr_q, perr_d;
   logic          valid_q, valid_d;
   logic          meta_q, sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         meta_q  <= rx;
         sync_q  <= meta_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      perr_d  = perr_q;
      valid_d = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d  = '0;
            bit_d  = '0;
            perr_d = 1'b0;
            if (!sync_q) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               state_d = sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == CPB_M1) begin
               cnt_d   = '0;
               shift_d = {sync_q, shift_q[7:1]};
               if (bit_q == 4'd7) begin
                  bit_d   = '0;
                  state_d = (PARITY_BIT != 0) ? RX_PARITY : RX_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         RX_PARITY: begin
            // A parity error is remembered and the frame is still run to its end,
            // so the parity bit itself can never be mistaken for a new start bit.
            if (cnt_q == CPB_M1) begin
               cnt_d   = '0;
               perr_d  = sync_q ^ even_parity(shift_q);
               state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == CPB_M1) begin
               cnt_d = '0;
               if (!sync_q) begin
                  state_d = RX_WAIT_IDLE;
               end else if (bit_q == LAST_STOP) begin
                  state_d = RX_IDLE;
                  if (!perr_q) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         RX_WAIT_IDLE: begin
            cnt_d = '0;
            if (sync_q) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // A low synchronized line already counts as busy, one cycle ahead of the START state.
   assign rx_busy  = (state_q != RX_IDLE) || !sync_q;
   assign rx_data  = data_q;
   assign rx_valid = valid_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int INPUT_CLK  = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int STOP_BITS  = 2,
   parameter int PARITY_BIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx
);

   localparam int CPB = calc_cpb(INPUT_CLK, BAUD_RATE);
   localparam int CW  = cnt_width(CPB);
   localparam logic [CW-1:0] CPB_M1    = CW'(CPB - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

   tx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic          tx_q, tx_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   // tx_d holds the level of the bit that begins on the next edge, so the line is glitch-free.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      case (state_q)
         TX_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            tx_d  = 1'b1;
            if (tx_start) begin
               shift_d = tx_data;
               par_d   = even_parity(tx_data);
               tx_d    = 1'b0;
               state_d = TX_START;
            end
         end
         default: begin
            if (cnt_q != CPB_M1) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               case (state_q)
                  TX_START: begin
                     state_d = TX_DATA;
                     bit_d   = '0;
                     tx_d    = shift_q[0];
                  end
                  TX_DATA: begin
                     if (bit_q == 4'd7) begin
                        bit_d = '0;
                        if (PARITY_BIT != 0) begin
                           state_d = TX_PARITY;
                           tx_d    = par_q;
                        end else begin
                           state_d = TX_STOP;
                           tx_d    = 1'b1;
                        end
                     end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                     end
                  end
                  TX_PARITY: begin
                     state_d = TX_STOP;
                     bit_d   = '0;
                     tx_d    = 1'b1;
                  end
                  TX_STOP: begin
                     tx_d = 1'b1;
                     if (bit_q == LAST_STOP) state_d = TX_IDLE;
                     else                    bit_d   = bit_q + 1'b1;
                  end
                  default: state_d = TX_IDLE;
               endcase
            end
         end
      endcase
   end

   assign tx_busy = (state_q != TX_IDLE);
   assign tx      = tx_q;

endmodule

// File: rtl/uart.sv
// Full-duplex 8-bit UART: independent transmitter and receiver on one clock.
module uart
   import uart_pkg::*;
#(
   parameter int INPUT_CLK  = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int STOP_BITS  = 2,
   parameter int PARITY_BIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_busy,
   output logic       rx_valid
);

   uart_tx #(
      .INPUT_CLK (INPUT_CLK),
      .BAUD_RATE (BAUD_RATE),
      .STOP_BITS (STOP_BITS),
      .PARITY_BIT(PARITY_BIT)
   ) u_tx (
      .clk     (clk),
      .reset   (reset),
      .tx_start(tx_start),
      .tx_data (tx_data),
      .tx_busy (tx_busy),
      .tx      (tx)
   );

   uart_rx #(
      .INPUT_CLK (INPUT_CLK),
      .BAUD_RATE (BAUD_RATE),
      .STOP_BITS (STOP_BITS),
      .PARITY_BIT(PARITY_BIT)
   ) u_rx (
      .clk     (clk),
      .reset   (reset),
      .rx      (rx),
      .rx_data (rx_data),
      .rx_busy (rx_busy),
      .rx_valid(rx_valid)
   );

endmodule

// File: tb/tb_uart.sv
// Directed bench for uart: loopback, back-to-back, break, glitch, bad parity, mid-frame reset.
module tb_uart;

   // Scaled-down clock/baud keeps the frame short: 32 cycles per bit, 12 bits per frame.
   localparam int CLK_HZ = 3_200_000;
   localparam int BAUD   = 100_000;
   localparam int CPB    = 32;
   localparam int FRAME  = 12 * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_busy, tx;
   logic [7:0] rx_data;
   logic       rx_busy, rx_valid;

   logic loop_en = 1'b1;
   logic brk     = 1'b0;
   logic rx_man  = 1'b1;
   logic rx_line;
   assign rx_line = loop_en ? (tx & ~brk) : rx_man;

   int         n_cmp = 0;
   int         n_err = 0;
   int         len;
   logic [11:0] frame_seen;
   logic       seen_busy;
   logic [7:0] rxq[$];

   uart #(
      .INPUT_CLK (CLK_HZ),
      .BAUD_RATE (BAUD),
      .STOP_BITS (2),
      .PARITY_BIT(1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .tx_start(tx_start),
      .tx_data (tx_data),
      .tx_busy (tx_busy),
      .tx      (tx),
      .rx      (rx_line),
      .rx_data (rx_data),
      .rx_busy (rx_busy),
      .rx_valid(rx_valid)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) rxq.push_back(rx_data);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_tx_done();
      int n = 0;
      while (tx_busy && n < 2 * FRAME) begin
         tick(1);
         n++;
      end
      chk("tx_done_timeout", {31'd0, tx_busy}, 32'd0);
   endtask

   task automatic send(input logic [7:0] b, input int hold);
      tx_data  = b;
      tx_start = 1'b1;
      tick(hold);
      tx_start = 1'b0;
   endtask

   task automatic drive_frame(input logic [11:0] f);
      for (int k = 0; k < 12; k++) begin
         rx_man = f[k];
         tick(CPB);
      end
   endtask

   initial begin
      // Reset values
      tick(3);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
      chk("rst_rx_data", {24'd0, rx_data}, 32'h00);
      chk("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      reset = 1'b0;
      tick(2);

      // Loopback 0x3D: frame bits, tx_busy length, received byte
      send(8'h3D, 1);
      chk("tx_start_bit", {31'd0, tx}, 32'd0);
      chk("tx_busy_rise", {31'd0, tx_busy}, 32'd1);
      len = 0;
      frame_seen = '0;
      while (tx_busy && len < 2 * FRAME) begin
         len++;
         for (int k = 0; k < 12; k++)
            if (len == k * CPB + CPB / 2) frame_seen[k] = tx;
         tick(1);
      end
      chk("tx_frame_3D", {20'd0, frame_seen}, 32'hE7A);
      chk("tx_busy_len", len, FRAME);
      tick(4);
      chk("lb1_count", rxq.size(), 1);
      chk("lb1_data", {24'd0, rx_data}, 32'h3D);
      chk("lb1_rx_busy", {31'd0, rx_busy}, 32'd0);
      $display("txn loopback 0x3D: busy_len=%0d rx=0x%0h", len, rx_data);

      // Back-to-back with tx_start held two cycles
      wait_tx_done();
      send(8'hC3, 2);
      wait_tx_done();
      send(8'hAA, 2);
      wait_tx_done();
      send(8'h55, 2);
      wait_tx_done();
      tick(CPB);
      chk("b2b_count", rxq.size(), 4);
      if (rxq.size() == 4) begin
         chk("b2b_byte0", {24'd0, rxq[1]}, 32'hC3);
         chk("b2b_byte1", {24'd0, rxq[2]}, 32'hAA);
         chk("b2b_byte2", {24'd0, rxq[3]}, 32'h55);
      end
      $display("txn back-to-back C3/AA/55: received %0d bytes total", rxq.size());

      // Break from bit 8 until past the end of a 0x55 frame
      send(8'h55, 1);
      tick(8 * CPB - 1);
      brk = 1'b1;
      tick(4 * CPB + CPB / 2);
      chk("brk_tx_idle", {31'd0, tx_busy}, 32'd0);
      chk("brk_wait_idle_busy", {31'd0, rx_busy}, 32'd1);
      tick(CPB / 2);
      brk = 1'b0;
      tick(4);
      chk("brk_rx_busy_clear", {31'd0, rx_busy}, 32'd0);
      chk("brk_count", rxq.size(), 4);
      chk("brk_data_kept", {24'd0, rx_data}, 32'h55);
      send(8'h3D, 1);
      wait_tx_done();
      tick(4);
      chk("post_brk_count", rxq.size(), 5);
      chk("post_brk_data", {24'd0, rx_data}, 32'h3D);
      $display("txn break then 0x3D: rx=0x%0h count=%0d", rx_data, rxq.size());

      // Two-cycle glitch on idle line
      loop_en = 1'b0;
      rx_man  = 1'b1;
      tick(4);
      rx_man = 1'b0;
      tick(1);
      chk("glitch_busy_sync1", {31'd0, rx_busy}, 32'd0);
      tick(1);
      rx_man = 1'b1;
      chk("glitch_busy_rise", {31'd0, rx_busy}, 32'd1);
      seen_busy = 1'b0;
      tick(CPB);
      chk("glitch_busy_fall", {31'd0, rx_busy}, 32'd0);
      chk("glitch_count", rxq.size(), 5);
      $display("txn glitch: rx_busy=%0b count=%0d", rx_busy, rxq.size());

      // 0x3D with parity bit forced to 0, then a good manual 0xA5 frame
      drive_frame(12'hC7A);
      tick(CPB);
      chk("perr_count", rxq.size(), 5);
      chk("perr_data_kept", {24'd0, rx_data}, 32'h3D);
      chk("perr_rx_busy", {31'd0, rx_busy}, 32'd0);
      drive_frame(12'hD4A);
      tick(4);
      chk("man_count", rxq.size(), 6);
      chk("man_data", {24'd0, rx_data}, 32'hA5);
      $display("txn bad parity 0x3D then 0xA5: rx=0x%0h count=%0d", rx_data, rxq.size());

      // Reset in mid-frame on both sides
      loop_en = 1'b1;
      tick(2);
      send(8'hAA, 1);
      tick(5 * CPB);
      reset = 1'b1;
      #1;
      chk("mid_rst_tx", {31'd0, tx}, 32'd1);
      chk("mid_rst_tx_busy", {31'd0, tx_busy}, 32'd0);
      chk("mid_rst_rx_data", {24'd0, rx_data}, 32'h00);
      chk("mid_rst_rx_busy", {31'd0, rx_busy}, 32'd0);
      chk("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      tick(2);
      reset = 1'b0;
      tick(2);
      send(8'h81, 1);
      wait_tx_done();
      tick(4);
      chk("post_rst_count", rxq.size(), 7);
      chk("post_rst_data", {24'd0, rx_data}, 32'h81);
      $display("txn reset mid-frame then 0x81: rx=0x%0h count=%0d", rx_data, rxq.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart.md
# uart

Full-duplex 8-bit asynchronous serial port: a transmitter that serializes a byte on `tx` and a receiver that deserializes `rx`, sharing one clock and reset. Bit timing, parity and stop-bit count are fixed by parameters at elaboration. It sits between a byte-level host interface and the board UART pins; looping `tx` to `rx` gives a self-test path.

## Interface
- `INPUT_CLK`, 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s. `CPB = INPUT_CLK / BAUD_RATE` (integer division, 868 at defaults). `CPB` must be at least 16.
- `STOP_BITS`, 2: number of stop bits, 1 or 2.
- `PARITY_BIT`, 1: 0 means no parity; 1 means one even-parity bit.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tx_start`  in  1  transmit request, sampled only when idle.
- `tx_data`  in  8  byte to send, latched on an accepted `tx_start`.
- `tx_busy`  out  1  high while a frame is in progress.
- `tx`  out  1  serial output, idle high.
- `rx`  in  1  serial input, asynchronous.
- `rx_data`  out  8  last correctly received byte.
- `rx_busy`  out  1  high while a frame is being received.
- `rx_valid`  out  1  one-cycle pulse when a good byte is received.

## Operation
- Frame: start bit (0), data bits D0..D7 LSB first, optional parity bit (XOR of the 8 data bits), then `STOP_BITS` stop bits (1). Each bit lasts `CPB` cycles.
- TX states: IDLE → START → DATA(8) → PARITY (skipped if `PARITY_BIT=0`) → STOP(`STOP_BITS`) → IDLE.
  - In IDLE, `tx_start=1` latches `tx_data` and enters START.
  - `tx_start` is ignored outside IDLE; holding it high for several cycles still sends exactly one frame.
  - A new frame can be accepted in the cycle after `tx_busy` falls.
- RX input: `rx` passes through a 2-flop synchronizer; all RX logic uses the synchronized signal.
- RX states: IDLE → START → DATA → PARITY → STOP → (WAIT_IDLE) → IDLE.
  - A falling edge in IDLE enters START.
  - At half-bit (`CPB/2`) the start bit is rechecked. If the line is high, the edge was a glitch: return to IDLE with no output.
  - After that, each bit is sampled every `CPB` cycles, at mid-bit.
- Error handling:
  - On a parity mismatch, or any stop bit sampled low, the byte is discarded: no `rx_valid`, `rx_data` unchanged.
  - After any stop bit sampled low (framing error or break), RX goes to WAIT_IDLE and stays there until the line is high.
- On success, at the mid-point of the last stop bit: `rx_data` is updated and `rx_valid` pulses for exactly one cycle.

## Timing
- Reset values: `tx=1`, `tx_busy=0`, `rx_data=0`, `rx_busy=0`, `rx_valid=0`, both FSMs in IDLE. Reset mid-frame aborts immediately to these values.
- TX latency: on the edge that samples `tx_start` in IDLE, `tx` goes 0 and `tx_busy` goes 1.
- TX duration: `tx_busy` stays high for `(1+8+PARITY_BIT+STOP_BITS)*CPB` cycles, which is 10416 at the defaults. It falls on the same edge the last stop bit ends.
- `rx_busy`: rises two cycles after `rx` falls (synchronizer delay). It falls on the cycle `rx_valid` pulses, or when an error or glitch is detected. During WAIT_IDLE it stays high until the line returns high.
- Counters: bit-period counter `ceil(log2(CPB))` bits, wraps to 0 at `CPB-1`. Bit index counter 4 bits.

## Structure
- Top level `uart` instantiates two sub-modules, `uart_tx` and `uart_rx`, with identical parameters.
- A shared package `uart_pkg` holds:
  - `CPB` and counter-width calculations;
  - the FSM state encodings;
  - a parity function.

## Test plan
- Loopback (`rx` tied to `tx`, defaults), send 0x3D: parity bit is 1 and two stop bits follow. `rx_valid` pulses once with `rx_data=0x3D`. `tx_busy` is high for 10416 cycles.
- Back-to-back loopback of 0xC3, 0xAA, 0x55, with `tx_start` held 2 cycles each: each byte is received once, in order, with no extra `rx_valid`.
- Force `rx` low for 20 µs in the middle of a 0x55 frame, then release: no `rx_valid`, `rx_data` unchanged. RX waits for the line to go high, then correctly receives the next frame, 0x3D.
- A 2-cycle low glitch on an idle `rx`: `rx_busy` pulses briefly, then RX returns to IDLE with no `rx_valid`.
- Drive 0x3D with a wrong parity bit (0): no `rx_valid`, `rx_data` unchanged.
- Assert `reset` mid-frame on both sides: all outputs immediately return to reset values. A frame sent after reset is released is received correctly.
